bit_unstuff: RTL and testbench
==============================

// Module: bit_unstuff
// PURPOSE
//  USB receive-path stage directly downstream of nrzi_decode; consumes its
//  decoded bit stream. Hunts for the SYNC pattern and removes each stuffed 0
//  that follows STUFF_LEN consecutive 1s. Flags stuffing violations and frames
//  each packet with start/end pulses for the downstream deserializer.
// PARAMETERS
//  STUFF_LEN     6   consecutive 1s after which the next bit must be a stuffed 0
//  SYNC_LEN      8   SYNC length in bits; decoded SYNC = (SYNC_LEN-1) 0s then one 1
//  SYNC_TIMEOUT  32  valid bits allowed in HUNT before declaring ERR
// PORTS
//  clk        in   1  clock; all state changes on posedge
//  rst_L      in   1  synchronous active-low reset
//  inb        in   1  decoded bit from nrzi_decode
//  in_valid   in   1  inb is a new bit this cycle (one-cycle strobe)
//  recving    in   1  line activity; low forces IDLE
//  eop        in   1  end-of-packet strobe from upstream
//  outb       out  1  unstuffed data bit
//  out_valid  out  1  outb valid this cycle
//  pkt_start  out  1  one-cycle pulse: SYNC matched
//  pkt_end    out  1  one-cycle pulse: packet closed (eop or abort)
//  aborted    out  1  one-cycle pulse, coincident with pkt_end, when recving fell mid-packet
//  stuff_err  out  1  one-cycle pulse: 1 received where a stuffed 0 was required
// BEHAVIOUR
//  - Reset (rst_L=0 at posedge): state=IDLE, shift reg=0, counters=0, all outputs 0.
//  - All outputs registered: response appears the cycle after the sampling edge.
//    outb holds its last value when out_valid=0.
//  - States: IDLE, HUNT, DATA, ERR. Priority each cycle: recving=0 > eop > in_valid.
//  - IDLE: recving=1 -> HUNT; clear shift reg and timeout counter.
//  - HUNT: on in_valid, shift inb into SYNC_LEN-bit reg and increment timeout
//    counter.
//      - Shifted value == {0..0,1} -> DATA; pkt_start=1; ones_cnt=1, since the
//        SYNC trailing 1 counts toward stuffing.
//      - Else timeout counter reaches SYNC_TIMEOUT -> ERR.
//      - eop -> IDLE, no pkt_end.
//  - DATA, on in_valid:
//      - ones_cnt==STUFF_LEN and inb=0: drop bit (out_valid=0), ones_cnt=0.
//      - ones_cnt==STUFF_LEN and inb=1: stuff_err=1 -> ERR.
//      - Otherwise: outb=inb, out_valid=1; ones_cnt = inb ? ones_cnt+1 : 0.
//  - DATA, eop: pkt_end=1 -> IDLE; any in_valid bit in the same cycle is discarded.
//  - DATA, recving=0: pkt_end=1, aborted=1 -> IDLE.
//  - ERR: ignore bits. eop or recving=0 -> IDLE; no pkt_end or aborted from ERR.
//  - Widths: ones_cnt is $clog2(STUFF_LEN+1) bits; timeout counter is
//    $clog2(SYNC_TIMEOUT+1) bits and saturates.
//  - rst_L low mid-packet: immediate return to IDLE; no pkt_end or aborted pulse.
//  - Invariant: at most one of pkt_start, pkt_end, stuff_err is asserted per cycle.
// TESTING
//  1. Reset with in_valid toggling -> all outputs 0, state IDLE.
//  2. recving=1; bits 0000000 1, then 1010 0011, then eop ->
//     pkt_start 1 cycle after the 8th bit; 8 out_valid with bits 1,0,1,0,0,0,1,1;
//     pkt_end 1 cycle after eop.
//  3. After SYNC: 11111 then 0 (stuffed, since SYNC 1 makes six) then 1 ->
//     out bits 1,1,1,1,1,1; the 0 is dropped; ones_cnt=0 then 1.
//  4. After SYNC: 1111111 -> 5 data 1s out, stuff_err pulse on the 6th data 1;
//     no further out_valid until eop, and no pkt_end.
//  5. HUNT with 32 valid 1s and no SYNC -> ERR, no pkt_start;
//     recving=0 -> IDLE.
//  6. recving drops after 3 data bits -> pkt_end=1 and aborted=1 same cycle;
//     same-cycle eop+in_valid in DATA -> pkt_end, bit not emitted.

Source files
------------

// File: rtl/bit_unstuff.sv
// USB receive bit unstuffer: hunts for SYNC, removes stuffed zeros, frames
// each packet with start/end pulses and flags stuffing violations.
module bit_unstuff #(
  parameter int STUFF_LEN    = 6,
  parameter int SYNC_LEN     = 8,
  parameter int SYNC_TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_L,
  input  logic inb,
  input  logic in_valid,
  input  logic recving,
  input  logic eop,
  output logic outb,
  output logic out_valid,
  output logic pkt_start,
  output logic pkt_end,
  output logic aborted,
  output logic stuff_err
);

  localparam int OC_W = $clog2(STUFF_LEN + 1);
  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);

  localparam logic [SYNC_LEN-1:0] SYNC_PAT  = SYNC_LEN'(1);
  localparam logic [OC_W-1:0]     STUFF_MAX = OC_W'(STUFF_LEN);
  localparam logic [TO_W-1:0]     TO_MAX    = TO_W'(SYNC_TIMEOUT);
  localparam logic [TO_W-1:0]     SYNC_MIN  = TO_W'(SYNC_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HUNT = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_LEN-1:0] sr_q, sr_d;
  logic [OC_W-1:0]     ones_q, ones_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                outb_q, outb_d;
  logic                outv_q, outv_d;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic                abort_q, abort_d;
  logic                serr_q, serr_d;

  logic [SYNC_LEN-1:0] sr_shift;
  logic [TO_W-1:0]     to_inc;

  assign sr_shift = {sr_q[SYNC_LEN-2:0], inb};
  assign to_inc   = (to_q == TO_MAX) ? to_q : to_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ones_d  = ones_q;
    to_d    = to_q;
    outb_d  = outb_q;
    outv_d  = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    abort_d = 1'b0;
    serr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (recving) begin
          state_d = S_HUNT;
          sr_d    = '0;
          to_d    = '0;
        end
      end

      S_HUNT: begin
        if (!recving || eop) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          sr_d = sr_shift;
          to_d = to_inc;
          // A match only counts once a full SYNC window has been shifted in,
          // so the cleared register cannot fake a SYNC from a lone 1.
          if (sr_shift == SYNC_PAT && to_inc >= SYNC_MIN) begin
            state_d = S_DATA;
            start_d = 1'b1;
            ones_d  = OC_W'(1);
          end else if (to_inc >= TO_MAX) begin
            state_d = S_ERR;
          end
        end
      end

      S_DATA: begin
        if (!recving) begin
          state_d = S_IDLE;
          end_d   = 1'b1;
          abort_d = 1'b1;
        end else if (eop) begin
          state_d = S_IDLE;
          end_d   = 1'b1;
        end else if (in_valid) begin
          if (ones_q == STUFF_MAX) begin
            if (inb) begin
              state_d = S_ERR;
              serr_d  = 1'b1;
            end else begin
              ones_d = '0;
            end
          end else begin
            outb_d = inb;
            outv_d = 1'b1;
            ones_d = inb ? ones_q + 1'b1 : '0;
          end
        end
      end

      S_ERR: begin
        if (!recving || eop) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      ones_q  <= '0;
      to_q    <= '0;
      outb_q  <= 1'b0;
      outv_q  <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ones_q  <= ones_d;
      to_q    <= to_d;
      outb_q  <= outb_d;
      outv_q  <= outv_d;
      start_q <= start_d;
      end_q   <= end_d;
      abort_q <= abort_d;
      serr_q  <= serr_d;
    end
  end

  assign outb      = outb_q;
  assign out_valid = outv_q;
  assign pkt_start = start_q;
  assign pkt_end   = end_q;
  assign aborted   = abort_q;
  assign stuff_err = serr_q;

endmodule

// File: tb/tb_bit_unstuff.sv
// Directed bench for bit_unstuff: SYNC hunt, unstuffing, violations,
// timeout, abort and reset behaviour, checked with immediate assertions.
module tb_bit_unstuff;

  logic clk;
  logic rst_L;
  logic inb;
  logic in_valid;
  logic recving;
  logic eop;
  logic outb;
  logic out_valid;
  logic pkt_start;
  logic pkt_end;
  logic aborted;
  logic stuff_err;

  int n_cmp = 0;
  int n_err = 0;

  // flag vector order: {out_valid, pkt_start, pkt_end, aborted, stuff_err}
  localparam logic [4:0] F_NONE  = 5'b00000;
  localparam logic [4:0] F_OUT   = 5'b10000;
  localparam logic [4:0] F_START = 5'b01000;
  localparam logic [4:0] F_END   = 5'b00100;
  localparam logic [4:0] F_ABORT = 5'b00110;
  localparam logic [4:0] F_SERR  = 5'b00001;

  bit_unstuff dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .inb       (inb),
    .in_valid  (in_valid),
    .recving   (recving),
    .eop       (eop),
    .outb      (outb),
    .out_valid (out_valid),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .aborted   (aborted),
    .stuff_err (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {27'b0, out_valid, pkt_start, pkt_end, aborted, stuff_err}, {27'b0, exp});
  endtask

  task automatic send_bit(input logic b);
    inb      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Emits a data bit and expects it on the output the next cycle.
  task automatic data_bit(input string tag, input logic b);
    send_bit(b);
    chk_flags({tag, "_flags"}, F_OUT);
    chk({tag, "_outb"}, {31'b0, outb}, {31'b0, b});
  endtask

  // From IDLE: raise recving, enter HUNT, then send decoded SYNC.
  task automatic start_pkt(input string tag);
    recving = 1'b1;
    tick();
    chk_flags({tag, "_hunt"}, F_NONE);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    chk_flags({tag, "_presync"}, F_NONE);
    send_bit(1'b1);
    chk_flags({tag, "_pkt_start"}, F_START);
    tick();
    chk_flags({tag, "_start_pulse"}, F_NONE);
  endtask

  logic [7:0] pat;

  initial begin
    rst_L    = 1'b0;
    inb      = 1'b1;
    in_valid = 1'b0;
    recving  = 1'b1;
    eop      = 1'b0;

    // Reset with in_valid toggling
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      tick();
      chk_flags($sformatf("rst_flags%0d", i), F_NONE);
      chk($sformatf("rst_outb%0d", i), {31'b0, outb}, 32'd0);
    end
    in_valid = 1'b0;
    recving  = 1'b0;
    rst_L    = 1'b1;
    tick();
    chk_flags("idle_after_rst", F_NONE);

    // Basic packet: SYNC, then 1010 0011, then eop
    start_pkt("t2");
    pat = 8'b1010_0011;
    for (int i = 7; i >= 0; i--) data_bit($sformatf("t2_d%0d", 7 - i), pat[i]);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    chk_flags("t2_pkt_end", F_END);
    tick();
    chk_flags("t2_end_pulse", F_NONE);

    // Stuffed zero after SYNC 1 plus five data 1s
    recving = 1'b0;
    tick();
    start_pkt("t3");
    for (int i = 0; i < 5; i++) data_bit($sformatf("t3_one%0d", i), 1'b1);
    send_bit(1'b0);
    chk_flags("t3_stuff_drop", F_NONE);
    chk("t3_outb_hold", {31'b0, outb}, 32'd1);
    data_bit("t3_after1", 1'b1);
    data_bit("t3_after0", 1'b0);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    chk_flags("t3_pkt_end", F_END);

    // Stuffing violation
    recving = 1'b0;
    tick();
    start_pkt("t4");
    for (int i = 0; i < 5; i++) data_bit($sformatf("t4_one%0d", i), 1'b1);
    send_bit(1'b1);
    chk_flags("t4_stuff_err", F_SERR);
    send_bit(1'b1);
    chk_flags("t4_err_ignore1", F_NONE);
    send_bit(1'b0);
    chk_flags("t4_err_ignore0", F_NONE);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    chk_flags("t4_no_pkt_end", F_NONE);

    // SYNC timeout: 32 ones in HUNT, then a SYNC must be ignored in ERR
    recving = 1'b0;
    tick();
    recving = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    chk_flags("t5_timeout", F_NONE);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    chk_flags("t5_err_no_start", F_NONE);
    recving = 1'b0;
    tick();
    chk_flags("t5_err_no_end", F_NONE);

    // Abort: recving drops after 3 data bits
    start_pkt("t6a");
    data_bit("t6a_d0", 1'b1);
    data_bit("t6a_d1", 1'b0);
    data_bit("t6a_d2", 1'b1);
    recving = 1'b0;
    tick();
    chk_flags("t6a_abort", F_ABORT);
    tick();
    chk_flags("t6a_abort_pulse", F_NONE);

    // eop with a same-cycle bit: bit discarded, packet closed
    start_pkt("t6b");
    data_bit("t6b_d0", 1'b0);
    eop      = 1'b1;
    inb      = 1'b1;
    in_valid = 1'b1;
    tick();
    eop      = 1'b0;
    in_valid = 1'b0;
    chk_flags("t6b_eop_bit", F_END);
    chk("t6b_outb_hold", {31'b0, outb}, 32'd0);

    // Reset mid-packet: straight to IDLE with no end/abort pulse
    recving = 1'b0;
    tick();
    start_pkt("t7");
    data_bit("t7_d0", 1'b1);
    rst_L = 1'b0;
    inb      = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_flags("t7_rst_flags", F_NONE);
    chk("t7_rst_outb", {31'b0, outb}, 32'd0);
    rst_L = 1'b1;
    recving = 1'b0;
    tick();
    chk_flags("t7_idle", F_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
